// File: rtl/raptor_bus_pkg.sv
//==============================================================================
// Module      : raptor_bus_pkg
// Description : Shared types and default widths for the core-to-memory bus.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package raptor_bus_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } arb_state_e;

endpackage : raptor_bus_pkg

`default_nettype wire

// File: rtl/mem_arb_pick.sv
//==============================================================================
// Module      : mem_arb_pick
// Description : Combinational winner selection between fetch and load/store.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arb_pick
  import raptor_bus_pkg::*;
(
  input  logic   if_req_i,
  input  logic   ls_req_i,
  input  logic   streak_at_limit_i,
  output logic   pick_valid_o,
  output owner_e pick_owner_o
);

  always_comb begin
    pick_valid_o = 1'b0;
    pick_owner_o = OWN_LS;
    if (ls_req_i && !streak_at_limit_i) begin
      pick_valid_o = 1'b1;
      pick_owner_o = OWN_LS;
    end else if (if_req_i) begin
      pick_valid_o = 1'b1;
      pick_owner_o = OWN_IF;
    end else if (ls_req_i) begin
      // Streak limit only matters while fetch is actually waiting.
      pick_valid_o = 1'b1;
      pick_owner_o = OWN_LS;
    end
  end

endmodule : mem_arb_pick

`default_nettype wire

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module      : mem_arbiter
// Description : Fetch / load-store arbiter onto a single unified memory port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arbiter
  import raptor_bus_pkg::*;
#(
  parameter int AW            = DEF_AW,
  parameter int DW            = DEF_DW,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int             C_SW         = $clog2(MAX_LS_STREAK + 1);
  localparam logic [C_SW-1:0] C_STREAK_MAX = C_SW'(MAX_LS_STREAK);

  arb_state_e      state_q, state_d;
  logic [C_SW-1:0] streak_q, streak_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [DW/8-1:0] mem_be_q, mem_be_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            ls_rvalid_q, ls_rvalid_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   ls_rdata_q, ls_rdata_d;

  logic            w_at_limit;
  logic            w_pick_valid;
  owner_e          w_pick_owner;

  assign w_at_limit = (streak_q == C_STREAK_MAX);

  mem_arb_pick u_pick (
    .if_req_i          (if_req),
    .ls_req_i          (ls_req),
    .streak_at_limit_i (w_at_limit),
    .pick_valid_o      (w_pick_valid),
    .pick_owner_o      (w_pick_owner)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;

    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held so no request is lost.
        if (!reset && w_pick_valid) begin
          mem_req_d = 1'b1;
          if (w_pick_owner == OWN_LS) begin
            ls_gnt      = 1'b1;
            state_d     = BUSY_LS;
            mem_we_d    = ls_we;
            mem_be_d    = ls_be;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            if (!if_req)
              streak_d = '0;
            else if (!w_at_limit)
              streak_d = streak_q + C_SW'(1);
          end else begin
            if_gnt      = 1'b1;
            state_d     = BUSY_IF;
            mem_we_d    = 1'b0;
            mem_be_d    = '0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end
      BUSY_IF: begin
        if (mem_ready) begin
          mem_req_d   = 1'b0;
          state_d     = IDLE;
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end
      end
      BUSY_LS: begin
        if (mem_ready) begin
          mem_req_d   = 1'b0;
          state_d     = IDLE;
          ls_rvalid_d = 1'b1;
          ls_rdata_d  = mem_we_q ? '0 : mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule : mem_arbiter

`default_nettype wire
